serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial N-bit unsigned subtractor that computes a - b one bit per clock, LSB first. A single borrow flip-flop chains the bits. It is the inverse-direction counterpart of the team's adder cells: a full-subtractor step built from two half-subtractor cells, wrapped in a start/busy/done handshake. It is intended for area-constrained datapaths where latency of WIDTH cycles is acceptable.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
busy  output  1  high while bits are being processed (SHIFT state)
done  output  1  single-cycle pulse; diff and borrow_out valid
diff  output  WIDTH  result a - b mod 2^WIDTH
borrow_out  output  1  final borrow; 1 iff a < b (unsigned)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, diff=0, borrow_out=0, internal shift registers, borrow and counter cleared. Reset mid-operation aborts the operation; no done pulse is produced for it.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if start=1 at edge k, load a_sh<=a, b_sh<=b, brw<=0, cnt<=0, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: at each edge, process bit i=cnt.
    - d = a_sh[0] ^ b_sh[0] ^ brw
    - brw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw)
    - Shift a_sh and b_sh right by 1. Shift res right, inserting d at the MSB. cnt <= cnt + 1.
    - When cnt == WIDTH-1 (last bit): diff <= final res, borrow_out <= brw_next, go to DONE.
  - DONE: lasts one cycle, then IDLE unconditionally.
- Outputs derive from registered state: busy = (state==SHIFT), done = (state==DONE).
- Latency: start accepted at edge k; busy is high from edge k+1 to edge k+WIDTH; done is high for exactly one cycle after edge k+WIDTH. Throughput is one operation per WIDTH+2 cycles.
- start while busy or in DONE is ignored; a and b changes during SHIFT have no effect.
- diff and borrow_out hold their last values until the next operation completes. They are not cleared on start.
- Counter width is $clog2(WIDTH+1). When WIDTH=1, the SHIFT state lasts one cycle and the counter does not wrap.
- Arithmetic is modulo 2^WIDTH; there is no signed interpretation.

Decomposition:
- Shared package sub_pkg: state encoding constants S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2.
- Sub-module half_subtractor (inputs x, y; outputs d = x^y, bo = ~x & y).
- The full-subtractor step is two half_subtractor instances: borrow = bo1 | bo2.

Test Plan:
- WIDTH=8, a=200, b=55, start pulse -> after 8 busy cycles, done=1 for 1 cycle, diff=145 (0x91), borrow_out=0.
- a=55, b=200 -> diff=0x6F (111), borrow_out=1.
- a=0, b=1 -> diff=0xFF, borrow_out=1. Then a=0xA5, b=0xA5 -> diff=0, borrow_out=0.
- Raise start again plus new operands on the 3rd busy cycle -> ignored; result still matches the first operands; exactly one done pulse.
- Assert rst_n low on the 4th SHIFT cycle -> busy=0, done=0, diff=0, borrow_out=0 immediately; no done pulse follows; the next operation computes correctly.
- WIDTH=1: all four (a,b) pairs -> diff/borrow_out = 00->0/0, 01->1/1, 10->1/0, 11->0/0; done arrives 1 cycle after busy.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage : sub_pkg

// File: rtl/serial_subtractor_if.sv
// Request/response bundle of the serial subtractor: operands in, result and status out.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );

endinterface : serial_subtractor_if

// File: rtl/serial_subtractor_half_sub.sv
// Half-subtractor cell: difference and borrow of x - y for single bits.
module half_subtractor (
  input  logic i_x,
  input  logic i_y,
  output logic o_d,
  output logic o_bo
);

  assign o_d  = i_x ^ i_y;
  assign o_bo = ~i_x & i_y;

endmodule : half_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, one bit per clock LSB first, with a
// single borrow flop chaining the bits and a start/busy/done handshake.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic [WIDTH-1:0] w_res_next;
  logic [CW-1:0]    r_cnt;
  logic             r_brw;
  logic             r_borrow_out;
  logic             r_busy;
  logic             r_done;
  logic             w_d1;
  logic             w_bo1;
  logic             w_d;
  logic             w_bo2;
  logic             w_brw_next;
  logic             w_last;

  // Full-subtractor step: (a - b) first, then subtract the incoming borrow.
  half_subtractor u_hs_ab (
    .i_x  (r_a_sh[0]),
    .i_y  (r_b_sh[0]),
    .o_d  (w_d1),
    .o_bo (w_bo1)
  );

  half_subtractor u_hs_brw (
    .i_x  (w_d1),
    .i_y  (r_brw),
    .o_d  (w_d),
    .o_bo (w_bo2)
  );

  assign w_brw_next = w_bo1 | w_bo2;
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_d;
    end else begin : g_res_wn
      assign w_res_next = {w_d, r_res[WIDTH-1:1]};
    end
  endgenerate

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_SHIFT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_SHIFT;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register; busy/done are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == S_SHIFT);
      r_done  <= (w_state_next == S_DONE);
    end
  end

  // Operand capture, bit-serial shifting and result hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh       <= '0;
      r_b_sh       <= '0;
      r_res        <= '0;
      r_brw        <= 1'b0;
      r_cnt        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_sh <= bus.a;
            r_b_sh <= bus.b;
            r_brw  <= 1'b0;
            r_cnt  <= '0;
          end
        end
        S_SHIFT: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_res  <= w_res_next;
          r_brw  <= w_brw_next;
          r_cnt  <= r_cnt + CW'(1);
          // diff/borrow_out only change here, so they hold across later starts.
          if (w_last) begin
            r_diff       <= w_res_next;
            r_borrow_out <= w_brw_next;
          end
        end
        S_DONE: begin
          r_cnt <= '0;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_borrow_out;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(1)) if1 ();

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt8 = 0;
  int done_cnt1 = 0;
  int bc8 = 0;
  int bc1 = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 8-bit instance: pop expected result on every done pulse.
  always @(negedge clk) begin
    logic [8:0] e8;
    if (!rst_n) begin
      bc8 = 0;
    end else begin
      if (if8.busy) bc8++;
      if (if8.done) begin
        done_cnt8++;
        if (q8.size() == 0) begin
          check("unexpected_done8", 32'd1, 32'd0);
        end else begin
          e8 = q8.pop_front();
          check("w8_result", {23'd0, if8.borrow_out, if8.diff}, {23'd0, e8});
          check("w8_busy_cycles", bc8, 32'd8);
        end
        bc8 = 0;
      end
    end
  end

  // Monitor for the 1-bit instance.
  always @(negedge clk) begin
    logic [1:0] e1;
    if (!rst_n) begin
      bc1 = 0;
    end else begin
      if (if1.busy) bc1++;
      if (if1.done) begin
        done_cnt1++;
        if (q1.size() == 0) begin
          check("unexpected_done1", 32'd1, 32'd0);
        end else begin
          e1 = q1.pop_front();
          check("w1_result", {30'd0, if1.borrow_out, if1.diff}, {30'd0, e1});
          check("w1_busy_cycles", bc1, 32'd1);
        end
        bc1 = 0;
      end
    end
  end

  task automatic wait_done(input bit w1);
    int start_cnt;
    bit seen;
    start_cnt = w1 ? done_cnt1 : done_cnt8;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = w1 ? (done_cnt1 != start_cnt) : (done_cnt8 != start_cnt);
    end
    if (!seen) check(w1 ? "timeout_w1" : "timeout_w8", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_op(input bit w1, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb);
    @(negedge clk);
    if (w1) begin
      if1.a = a[0];
      if1.b = b[0];
      if1.start = 1'b1;
      q1.push_back({eb, ed[0]});
    end else begin
      if8.a = a;
      if8.b = b;
      if8.start = 1'b1;
      q8.push_back({eb, ed});
    end
    @(negedge clk);
    if8.start = 1'b0;
    if1.start = 1'b0;
    wait_done(w1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy8"}, {31'd0, if8.busy}, 32'd0);
    check({tag, "_done8"}, {31'd0, if8.done}, 32'd0);
    check({tag, "_diff8"}, {24'd0, if8.diff}, 32'd0);
    check({tag, "_borrow8"}, {31'd0, if8.borrow_out}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0;
    #3 rst_n = 1'b0;
    #2;
    check_reset_outputs("reset");
    check("reset_w1", {30'd0, if1.busy, if1.done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(1'b0, 8'd200, 8'd55, 8'h91, 1'b0);
    run_op(1'b0, 8'd55, 8'd200, 8'h6F, 1'b1);
    run_op(1'b0, 8'h00, 8'h01, 8'hFF, 1'b1);
    run_op(1'b0, 8'hA5, 8'hA5, 8'h00, 1'b0);
    run_op(1'b0, 8'hFF, 8'hFE, 8'h01, 1'b0);

    // Start with new operands on the 3rd busy cycle must be ignored.
    @(negedge clk);
    if8.a = 8'h03; if8.b = 8'h10; if8.start = 1'b1;
    q8.push_back({1'b1, 8'hF3});
    @(negedge clk);
    if8.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("hold_diff_while_busy", {23'd0, if8.borrow_out, if8.diff}, {23'd0, 1'b0, 8'h01});
    check("busy_3rd_cycle", {31'd0, if8.busy}, 32'd1);
    if8.a = 8'hFF; if8.b = 8'h00; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    wait_done(1'b0);
    repeat (12) @(negedge clk);
    check("single_done_after_ignore", done_cnt8, 32'd6);

    // Reset in the 4th SHIFT cycle aborts the operation.
    @(negedge clk);
    if8.a = 8'h80; if8.b = 8'h01; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    check("no_done_after_abort", done_cnt8, 32'd6);
    run_op(1'b0, 8'h34, 8'h12, 8'h22, 1'b0);
    run_op(1'b0, 8'h00, 8'hFF, 8'h01, 1'b1);

    run_op(1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
    run_op(1'b1, 8'd0, 8'd1, 8'd1, 1'b1);
    run_op(1'b1, 8'd1, 8'd0, 8'd1, 1'b0);
    run_op(1'b1, 8'd1, 8'd1, 8'd0, 1'b0);

    check("queue8_drained", q8.size(), 32'd0);
    check("queue1_drained", q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_serial_subtractor
